// File: rtl/ahb_cpu_master.sv
`timescale 1ns/1ps
// ahb_cpu_master: turns one CPU load/store request into a single AHB-Lite NONSEQ
// transfer, absorbs HREADY wait states and two-cycle HRESP errors, and returns
// sign/zero-extended load data with a stall to hold the core.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   mem_read/mem_write load/store request, held by the core while stall=1
//   func3              RV32 access code (B/H/W/BU/HU)
//   address, rs2_data  byte address and LSB-aligned store data
//   data_out           extended load result, held until the next completed load
//   stall              combinational: core must hold its request
//   done, bus_err      one-cycle completion / error pulses
//   HADDR..HWDATA      AHB-Lite master outputs
//   HRDATA/HREADY/HRESP AHB-Lite slave responses
module ahb_cpu_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              bus_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [2:0]        func3_q,    func3_d;
    logic              write_q,    write_d;
    logic [DATA_W-1:0] hwdata_q,   hwdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q,     done_d;
    logic              bus_err_q,  bus_err_d;
    logic              stall_c;

    logic              req_c;
    logic              illegal_c;
    logic [DATA_W-1:0] wlanes_c;
    logic [7:0]        rd_byte_c;
    logic [15:0]       rd_half_c;
    logic [DATA_W-1:0] load_c;

    // Request legality: conflicting, reserved codes, unsigned stores, misalignment
    always_comb begin
        req_c     = mem_read | mem_write;
        illegal_c = 1'b0;
        if (mem_read && mem_write)                               illegal_c = 1'b1;
        if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) illegal_c = 1'b1;
        if (mem_write && func3[2])                               illegal_c = 1'b1;
        if (func3[1:0] == 2'b01 && address[0])                   illegal_c = 1'b1;
        if (func3[1:0] == 2'b10 && address[1:0] != 2'b00)        illegal_c = 1'b1;
    end

    // Store data replicated across all byte lanes so the slave can pick any lane
    always_comb begin
        case (func3[1:0])
            2'b00:   wlanes_c = DATA_W'({4{rs2_data[7:0]}});
            2'b01:   wlanes_c = DATA_W'({2{rs2_data[15:0]}});
            default: wlanes_c = rs2_data;
        endcase
    end

    // Load lane extraction and extension from the latched address/code
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_byte_c = HRDATA[7:0];
            2'b01:   rd_byte_c = HRDATA[15:8];
            2'b10:   rd_byte_c = HRDATA[23:16];
            default: rd_byte_c = HRDATA[31:24];
        endcase
        rd_half_c = addr_q[1] ? HRDATA[31:16] : HRDATA[15:0];
        case (func3_q)
            3'b000:  load_c = {{(DATA_W-8){rd_byte_c[7]}}, rd_byte_c};
            3'b001:  load_c = {{(DATA_W-16){rd_half_c[15]}}, rd_half_c};
            3'b100:  load_c = {{(DATA_W-8){1'b0}}, rd_byte_c};
            3'b101:  load_c = {{(DATA_W-16){1'b0}}, rd_half_c};
            default: load_c = HRDATA;
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        write_d    = write_q;
        hwdata_d   = hwdata_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        bus_err_d  = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (illegal_c) begin
                        bus_err_d = 1'b1;
                    end else begin
                        stall_c  = 1'b1;
                        addr_d   = address;
                        func3_d  = func3;
                        write_d  = mem_write;
                        hwdata_d = mem_write ? wlanes_c : '0;
                        state_d  = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                stall_c = 1'b1;
                if (HREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!HREADY) begin
                    stall_c = 1'b1;
                    if (HRESP) state_d = ST_ERR;
                end else if (HRESP) begin
                    // Single-cycle error response is treated like the second error cycle
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    done_d  = 1'b1;
                    if (!write_q) data_out_d = load_c;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Keep stall at its reset value while reset is held
        if (reset) stall_c = 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            func3_q    <= '0;
            write_q    <= 1'b0;
            hwdata_q   <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            func3_q    <= func3_d;
            write_q    <= write_d;
            hwdata_q   <= hwdata_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign HTRANS   = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR    = addr_q;
    assign HWRITE   = (state_q == ST_ADDR) && write_q;
    assign HSIZE    = {1'b0, func3_q[1:0]};
    assign HWDATA   = hwdata_q;
    assign data_out = data_out_q;
    assign done     = done_q;
    assign bus_err  = bus_err_q;
    assign stall    = stall_c;

endmodule

// File: tb/tb_ahb_cpu_master.sv
`timescale 1ns/1ps
// tb_ahb_cpu_master: directed load/store/error/reset scenarios with hand-computed
// expectations; the bench plays both the core and the AHB slave.
module tb_ahb_cpu_master;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] rs2_data;
    logic [31:0] data_out;
    logic        stall;
    logic        done;
    logic        bus_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_checks;
    int n_errors;
    logic [31:0] exp_dout;

    ahb_cpu_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .func3     (func3),
        .address   (address),
        .rs2_data  (rs2_data),
        .data_out  (data_out),
        .stall     (stall),
        .done      (done),
        .bus_err   (bus_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One legal access with a scripted slave; checks bus phases, stall, latency and result
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int addr_waits,
                             input int data_waits, input logic [31:0] exp_hwdata);
        int edges;
        edges     = 0;
        mem_read  = !wr;
        mem_write = wr;
        func3     = f3;
        address   = addr;
        rs2_data  = wdata;
        HRDATA    = rdata;
        HRESP     = 1'b0;
        HREADY    = 1'b1;
        #1;
        chk({tag, ".stall_req"}, 32'(stall), 32'd1);
        tick(); edges++;
        chk({tag, ".htrans"}, 32'(HTRANS), 32'd2);
        chk({tag, ".haddr"},  HADDR, addr);
        chk({tag, ".hwrite"}, 32'(HWRITE), 32'(wr));
        chk({tag, ".hsize"},  32'(HSIZE), {30'd0, f3[1:0]});
        for (int i = 0; i < addr_waits; i++) begin
            HREADY = 1'b0;
            #1;
            chk({tag, ".stall_aw"}, 32'(stall), 32'd1);
            tick(); edges++;
            chk({tag, ".htrans_aw"}, 32'(HTRANS), 32'd2);
        end
        HREADY = 1'b1;
        tick(); edges++;
        chk({tag, ".htrans_dp"}, 32'(HTRANS), 32'd0);
        for (int i = 0; i < data_waits; i++) begin
            HREADY = 1'b0;
            #1;
            chk({tag, ".stall_dw"}, 32'(stall), 32'd1);
            tick(); edges++;
        end
        HREADY = 1'b1;
        #1;
        chk({tag, ".stall_dp"}, 32'(stall), 32'd0);
        if (wr) chk({tag, ".hwdata"}, HWDATA, exp_hwdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick(); edges++;
        chk({tag, ".done"},    32'(done), 32'd1);
        chk({tag, ".bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, ".latency"}, 32'(edges), 32'(3 + addr_waits + data_waits));
        chk({tag, ".data_out"}, data_out, exp_dout);
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    // Illegal request: error pulse next cycle, no transfer, data_out untouched
    task automatic do_illegal(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        mem_read  = rd;
        mem_write = wr;
        func3     = f3;
        address   = addr;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({tag, ".bus_err"},  32'(bus_err), 32'd1);
        chk({tag, ".done"},     32'(done), 32'd0);
        chk({tag, ".htrans"},   32'(HTRANS), 32'd0);
        chk({tag, ".data_out"}, data_out, exp_dout);
        tick();
        chk({tag, ".err_pulse"}, 32'(bus_err), 32'd0);
        chk({tag, ".htrans2"},   32'(HTRANS), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_dout  = 32'h0;
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        func3     = 3'b000;
        address   = 32'h0;
        rs2_data  = 32'h0;
        HRDATA    = 32'h0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        tick();
        tick();
        chk("rst.htrans",   32'(HTRANS), 32'd0);
        chk("rst.haddr",    HADDR, 32'h0);
        chk("rst.hwrite",   32'(HWRITE), 32'd0);
        chk("rst.hsize",    32'(HSIZE), 32'd0);
        chk("rst.hwdata",   HWDATA, 32'h0);
        chk("rst.data_out", data_out, 32'h0);
        chk("rst.done",     32'(done), 32'd0);
        chk("rst.bus_err",  32'(bus_err), 32'd0);
        chk("rst.stall",    32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        exp_dout = 32'h8765_4321;
        do_access("lw_ram", 1'b0, 3'b010, 32'hB000_0004, 32'h0, 32'h8765_4321, 0, 0, 32'h0);
        do_access("sb",     1'b1, 3'b000, 32'hB000_0003, 32'h0000_00A5, 32'h0, 0, 0, 32'hA5A5_A5A5);
        do_access("sh",     1'b1, 3'b001, 32'hB000_0002, 32'hDEAD_BEEF, 32'h0, 0, 1, 32'hBEEF_BEEF);
        exp_dout = 32'hFFFF_FF80;
        do_access("lb",     1'b0, 3'b000, 32'hB000_0001, 32'h0, 32'h0000_8000, 0, 0, 32'h0);
        exp_dout = 32'h0000_0080;
        do_access("lbu",    1'b0, 3'b100, 32'hB000_0001, 32'h0, 32'h0000_8000, 0, 0, 32'h0);
        exp_dout = 32'h0000_007F;
        do_access("lb_l3",  1'b0, 3'b000, 32'hB000_0003, 32'h0, 32'h7F00_0000, 0, 0, 32'h0);
        exp_dout = 32'hFFFF_8000;
        do_access("lh_hi",  1'b0, 3'b001, 32'hB000_0002, 32'h0, 32'h8000_1234, 1, 0, 32'h0);
        exp_dout = 32'h0000_8000;
        do_access("lhu_hi", 1'b0, 3'b101, 32'hB000_0002, 32'h0, 32'h8000_1234, 0, 0, 32'h0);
        exp_dout = 32'h0000_7FFF;
        do_access("lh_lo",  1'b0, 3'b001, 32'hB000_0000, 32'h0, 32'h8000_7FFF, 0, 0, 32'h0);
        exp_dout = 32'h1234_5678;
        do_access("lw_rom_ws", 1'b0, 3'b010, 32'hA000_0004, 32'h0, 32'h1234_5678, 0, 2, 32'h0);

        // Two-cycle error response on a load
        mem_read = 1'b1; func3 = 3'b010; address = 32'hB000_0008;
        HRDATA = 32'hCAFE_F00D; HREADY = 1'b1; HRESP = 1'b0;
        tick();
        chk("err.htrans", 32'(HTRANS), 32'd2);
        tick();
        HRESP = 1'b1; HREADY = 1'b0;
        #1;
        chk("err.stall1", 32'(stall), 32'd1);
        tick();
        HREADY = 1'b1;
        #1;
        chk("err.stall2", 32'(stall), 32'd0);
        mem_read = 1'b0;
        tick();
        HRESP = 1'b0;
        chk("err.bus_err",  32'(bus_err), 32'd1);
        chk("err.done",     32'(done), 32'd0);
        chk("err.data_out", data_out, exp_dout);
        tick();
        chk("err.pulse",    32'(bus_err), 32'd0);
        chk("err.done2",    32'(done), 32'd0);

        do_illegal("mis_lw",  1'b1, 1'b0, 3'b010, 32'hB000_0002);
        do_illegal("mis_lh",  1'b1, 1'b0, 3'b001, 32'hB000_0001);
        do_illegal("sbu",     1'b0, 1'b1, 3'b100, 32'hB000_0000);
        do_illegal("rd_wr",   1'b1, 1'b1, 3'b010, 32'hB000_0000);
        do_illegal("f3_011",  1'b1, 1'b0, 3'b011, 32'hB000_0000);

        // Reset while in the data phase
        mem_read = 1'b1; func3 = 3'b010; address = 32'hB000_000C;
        HRDATA = 32'h5555_AAAA; HREADY = 1'b1; HRESP = 1'b0;
        tick();
        tick();
        HREADY = 1'b0;
        reset  = 1'b1;
        tick();
        chk("rstdp.htrans",   32'(HTRANS), 32'd0);
        chk("rstdp.stall",    32'(stall), 32'd0);
        chk("rstdp.done",     32'(done), 32'd0);
        chk("rstdp.bus_err",  32'(bus_err), 32'd0);
        chk("rstdp.data_out", data_out, 32'h0);
        reset    = 1'b0;
        mem_read = 1'b0;
        HREADY   = 1'b1;
        tick();
        chk("rstdp.done2",    32'(done), 32'd0);
        chk("rstdp.htrans2",  32'(HTRANS), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
